// File: rtl/encrypt_config.sv
// Shared encryption/decryption configuration: rotation width, rotation type and
// the byte right-rotate helper used by the decrypt shift stage.
package encrypt_config;

   localparam int ROT_W = 3;

   typedef logic [ROT_W-1:0] rot_t;

   // Result bit i takes source bit (i + rot) mod 8.
   function automatic logic [7:0] rotr8(input logic [7:0] x, input rot_t rot);
      logic [15:0] dbl;
      dbl = {x, x} >> rot;
      return dbl[7:0];
   endfunction

endpackage

// File: rtl/decrypt_pipe_shift_fifo.sv
// Output FIFO for the decrypt shift stage: parameterised width, show-ahead read,
// push accepted when full if a pop happens in the same cycle, synchronous clear.
module decrypt_out_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/decrypt_pipe_shift.sv
// Decrypt shift stage: rotates each byte right by the block schedule and buffers
// it in an output FIFO. Define DECRYPT_SHIFT_PARITY_EN to add dout_parity.
module decrypt_pipe_shift
   import encrypt_config::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int BLK_LEN    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             din_valid,
   input  logic [7:0]       din,
   input  logic [ROT_W-1:0] base_shift,
   input  logic             flush,
   output logic [7:0]       dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             fifo_full,
   output logic             overflow
`ifdef DECRYPT_SHIFT_PARITY_EN
   ,
   output logic             dout_parity
`endif
);

   localparam int IDX_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_LEN - 1);

`ifdef DECRYPT_SHIFT_PARITY_EN
   localparam int FIFO_W = 9;
`else
   localparam int FIFO_W = 8;
`endif

   logic [IDX_W-1:0]  idx;
   rot_t              rot;
   logic [7:0]        rotated;
   logic              s1_valid;
   logic [7:0]        s1_data;
   logic              s1_parity;
   logic [FIFO_W-1:0] fifo_wr;
   logic [FIFO_W-1:0] fifo_rd;
   logic              fifo_empty;
   logic              drop;

   assign rot     = base_shift + ROT_W'(idx);
   assign rotated = rotr8(din, rot);

   // Stage 1: rotate and advance the schedule index; idle mode parks it at 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx       <= '0;
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         s1_parity <= 1'b0;
      end else if (flush) begin
         idx      <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= 1'b0;
         if (!mode) begin
            idx <= '0;
         end else if (din_valid) begin
            s1_valid  <= 1'b1;
            s1_data   <= rotated;
            s1_parity <= ^rotated;
            idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end
      end
   end

   // A write into a full FIFO is lost only when the sink is not popping.
   assign drop = s1_valid && fifo_full && !dout_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         overflow <= 1'b0;
      else if (flush)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
   end

`ifdef DECRYPT_SHIFT_PARITY_EN
   assign fifo_wr     = {s1_parity, s1_data};
   assign dout        = fifo_rd[7:0];
   assign dout_parity = fifo_rd[8];
`else
   assign fifo_wr     = s1_data;
   assign dout        = fifo_rd;
`endif

   assign dout_valid = !fifo_empty;

   decrypt_out_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .push    (s1_valid),
      .wr_data (fifo_wr),
      .pop     (dout_ready),
      .rd_data (fifo_rd),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Parity is only carried through the FIFO when the port exists.
`ifndef DECRYPT_SHIFT_PARITY_EN
   logic unused_parity;
   assign unused_parity = s1_parity;
`endif

endmodule

// File: tb/tb_decrypt_pipe_shift.sv
// Scoreboard testbench for decrypt_pipe_shift (BLK_LEN=3, FIFO_DEPTH=4);
// also checks dout_parity when DECRYPT_SHIFT_PARITY_EN is defined.
module tb_decrypt_pipe_shift;

   localparam int BLK_LEN    = 3;
   localparam int FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mode = 1'b0;
   logic       din_valid = 1'b0;
   logic [7:0] din = 8'h00;
   logic [2:0] base_shift = 3'd0;
   logic       flush = 1'b0;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready = 1'b0;
   logic       fifo_full;
   logic       overflow;
`ifdef DECRYPT_SHIFT_PARITY_EN
   logic       dout_parity;
`endif

   int         checkCount = 0;
   int         failCount  = 0;
   int         popCount   = 0;
   int         popMark;
   int         mIdx = 0;
   logic [8:0] sb [$];
   logic [8:0] sbHead;

   decrypt_pipe_shift #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .BLK_LEN    (BLK_LEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .din_valid  (din_valid),
      .din        (din),
      .base_shift (base_shift),
      .flush      (flush),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .fifo_full  (fifo_full),
      .overflow   (overflow)
`ifdef DECRYPT_SHIFT_PARITY_EN
      ,
      .dout_parity (dout_parity)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] modelRotr(input logic [7:0] x, input int r);
      logic [7:0] y;
      for (int i = 0; i < 8; i++)
         y[i] = x[(i + r) % 8];
      return y;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one byte for one cycle; a kept byte's expected result goes on the scoreboard.
   task automatic applyStimulus(input logic [7:0] d, input bit keep);
      logic [7:0] r;
      r = modelRotr(d, (int'(base_shift) + mIdx) % 8);
      din       = d;
      din_valid = 1'b1;
      if (keep)
         sb.push_back({^r, r});
      mIdx = (mIdx == BLK_LEN - 1) ? 0 : mIdx + 1;
      tick();
      din_valid = 1'b0;
   endtask

   task automatic applyReset();
      rst       = 1'b0;
      din_valid = 1'b0;
      flush     = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      sb.delete();
      mIdx = 0;
   endtask

   task automatic waitDrain(input string tag);
      for (int i = 0; i < 40 && sb.size() != 0; i++)
         tick();
      checkOutput(tag, 16'(sb.size()), 16'd0);
   endtask

   // Sink side: every accepted byte must match the oldest scoreboard entry.
   always @(negedge clk) begin
      if (rst === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
         popCount++;
         if (sb.size() == 0) begin
            checkOutput("sb_spurious_pop", 16'(dout_valid), 16'd0);
         end else begin
            sbHead = sb.pop_front();
            checkOutput("sb_data", 16'(dout), 16'(sbHead[7:0]));
`ifdef DECRYPT_SHIFT_PARITY_EN
            checkOutput("sb_parity", 16'(dout_parity), 16'(sbHead[8]));
`endif
         end
      end
   end

   initial begin
      mode = 1'b1;

      // Reset state and basic rotation latency.
      base_shift = 3'd1;
      dout_ready = 1'b1;
      applyReset();
      checkOutput("rst_dout", 16'(dout), 16'h00);
      checkOutput("rst_dout_valid", 16'(dout_valid), 16'd0);
      checkOutput("rst_fifo_full", 16'(fifo_full), 16'd0);
      checkOutput("rst_overflow", 16'(overflow), 16'd0);
      applyStimulus(8'h81, 1'b1);
      checkOutput("lat_s1_only", 16'(dout_valid), 16'd0);
      tick();
      checkOutput("lat_valid", 16'(dout_valid), 16'd1);
      checkOutput("lat_data", 16'(dout), 16'hC0);
      applyStimulus(8'h81, 1'b1);
      waitDrain("rot_drain");

      // Schedule wrap at BLK_LEN: expected 01, 80, 40, 01.
      applyReset();
      base_shift = 3'd0;
      popMark    = popCount;
      for (int i = 0; i < 4; i++)
         applyStimulus(8'h01, 1'b1);
      waitDrain("wrap_drain");
      checkOutput("wrap_pops", 16'(popCount - popMark), 16'd4);

      // Backpressure: fifth byte dropped, overflow sticks through the drain.
      applyReset();
      dout_ready = 1'b0;
      base_shift = 3'd2;
      for (int i = 0; i < 5; i++)
         applyStimulus(8'h10 + 8'(i * 37), i < 4);
      tick();
      checkOutput("ovf_full", 16'(fifo_full), 16'd1);
      checkOutput("ovf_flag", 16'(overflow), 16'd1);
      popMark    = popCount;
      dout_ready = 1'b1;
      waitDrain("ovf_drain");
      tick();
      checkOutput("ovf_pops", 16'(popCount - popMark), 16'd4);
      checkOutput("ovf_sticky", 16'(overflow), 16'd1);
      checkOutput("ovf_empty", 16'(dout_valid), 16'd0);

      // Full FIFO with a simultaneous pop accepts the new byte.
      applyReset();
      dout_ready = 1'b0;
      base_shift = 3'd7;
      for (int i = 0; i < 4; i++)
         applyStimulus(8'hA0 + 8'(i), 1'b1);
      tick();
      checkOutput("fp_full_before", 16'(fifo_full), 16'd1);
      applyStimulus(8'h5A, 1'b1);
      dout_ready = 1'b1;
      tick();
      checkOutput("fp_full_after", 16'(fifo_full), 16'd1);
      checkOutput("fp_no_ovf", 16'(overflow), 16'd0);
      waitDrain("fp_drain");
      checkOutput("fp_no_ovf_end", 16'(overflow), 16'd0);

      // Idle mode ignores input and parks the schedule index at 0.
      applyReset();
      base_shift = 3'd5;
      applyStimulus(8'h3C, 1'b1);
      mode      = 1'b0;
      din       = 8'hFF;
      din_valid = 1'b1;
      for (int i = 0; i < 3; i++)
         tick();
      din_valid = 1'b0;
      mIdx      = 0;
      waitDrain("mode_drain");
      tick();
      checkOutput("mode_no_out", 16'(dout_valid), 16'd0);
      mode = 1'b1;
      applyStimulus(8'h3C, 1'b1);
      waitDrain("mode_resume");

      // Flush with three bytes buffered and overflow set.
      applyReset();
      dout_ready = 1'b0;
      base_shift = 3'd6;
      for (int i = 0; i < 5; i++)
         applyStimulus(8'hC3 ^ 8'(i), i < 4);
      tick();
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      checkOutput("flush_pre_ovf", 16'(overflow), 16'd1);
      checkOutput("flush_pre_valid", 16'(dout_valid), 16'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      sb.delete();
      mIdx = 0;
      checkOutput("flush_valid", 16'(dout_valid), 16'd0);
      checkOutput("flush_ovf", 16'(overflow), 16'd0);
      checkOutput("flush_dout", 16'(dout), 16'h00);

      // Asynchronous reset between edges clears outputs at once.
      applyReset();
      dout_ready = 1'b0;
      base_shift = 3'd3;
      for (int i = 0; i < 5; i++)
         applyStimulus(8'h77 + 8'(i), i < 4);
      tick();
      checkOutput("arst_pre_ovf", 16'(overflow), 16'd1);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("arst_valid", 16'(dout_valid), 16'd0);
      checkOutput("arst_full", 16'(fifo_full), 16'd0);
      checkOutput("arst_ovf", 16'(overflow), 16'd0);
      sb.delete();
      mIdx = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;

`ifdef DECRYPT_SHIFT_PARITY_EN
      // Rotation by 3 turns 8'h38 into 8'h07, which has odd weight.
      base_shift = 3'd3;
      dout_ready = 1'b1;
      applyStimulus(8'h38, 1'b1);
      tick();
      checkOutput("par_data", 16'(dout), 16'h07);
      checkOutput("par_bit", 16'(dout_parity), 16'd1);
      waitDrain("par_drain");
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
